// File: rtl/demux_dest_n.sv
// rtl/demux_dest_n.sv - destination demux with per-channel DEPTH-entry buffers and pause
// Optional drop counter: define DEMUX_DROP_CNT_EN; when undefined drop_cnt is tied to 0.
module demux_dest_n #(
  parameter int BW       = 6,
  parameter int SEL_LSB  = 4,
  parameter int SEL_W    = 1,
  parameter int NUM_DEST = 2,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   valid_in,
  input  logic [BW-1:0]          data_in,
  input  logic [NUM_DEST-1:0]    pause,
  output logic [NUM_DEST*BW-1:0] data_out,
  output logic [NUM_DEST-1:0]    valid_out,
  output logic [NUM_DEST-1:0]    full,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [SEL_W-1:0]    dest;
  logic [31:0]         dest_ext;
  logic [NUM_DEST-1:0] sel;
  logic [NUM_DEST-1:0] pop;
  logic [NUM_DEST-1:0] push;

  assign dest     = data_in[SEL_LSB +: SEL_W];
  assign dest_ext = 32'(dest);

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_ch
    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] dout_q;
    logic          vout_q;

    assign sel[i]  = valid_in && (dest_ext == 32'(i));
    assign pop[i]  = (count != '0) && !pause[i];
    // A full channel still accepts when it is draining on the same edge
    assign push[i] = sel[i] && ((count != FULL_CNT) || pop[i]);
    assign full[i] = (count == FULL_CNT);

    assign data_out[i*BW +: BW] = dout_q;
    assign valid_out[i]         = vout_q;

    always_ff @(posedge clk) begin
      if (reset_L) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        dout_q <= '0;
        vout_q <= 1'b0;
      end else begin
        if (push[i]) begin
          mem[wr_ptr] <= data_in;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop[i]) begin
          dout_q <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
        vout_q <= pop[i];
        case ({push[i], pop[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic             drop;
  logic [CNT_W-1:0] cnt_q;

  // Selected-but-not-pushed covers the full case; no select at all means a bad destination
  assign drop = valid_in && ((dest_ext >= 32'(NUM_DEST)) || ((sel & ~push) != '0));

  always_ff @(posedge clk) begin
    if (reset_L) begin
      cnt_q <= '0;
    end else if (drop && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign drop_cnt = cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_dest_n.sv
// tb/tb_demux_dest_n.sv - scoreboard bench for demux_dest_n (NUM_DEST=3, SEL_W=2, CNT_W=2)
module tb_demux_dest_n;

  localparam int BW = 6;
  localparam int ND = 3;

  logic          clk;
  logic          reset_L;
  logic          valid_in;
  logic [BW-1:0] data_in;
  logic [ND-1:0] pause;
  logic [ND*BW-1:0] data_out;
  logic [ND-1:0] valid_out;
  logic [ND-1:0] full;
  logic [1:0]    drop_cnt;

  int total = 0;
  int bad = 0;
  int exp_drop = 0;
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  logic [BW-1:0] q2[$];

  demux_dest_n #(
    .BW(BW), .SEL_LSB(4), .SEL_W(2), .NUM_DEST(ND), .DEPTH(4), .CNT_W(2)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .valid_in(valid_in),
    .data_in(data_in),
    .pause(pause),
    .data_out(data_out),
    .valid_out(valid_out),
    .full(full),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] d, input bit ok);
    valid_in = 1'b1;
    data_in  = d;
    if (ok) begin
      case (d[5:4])
        2'd0:    q0.push_back(d);
        2'd1:    q1.push_back(d);
        default: q2.push_back(d);
      endcase
    end else begin
`ifdef DEMUX_DROP_CNT_EN
      if (exp_drop < 3) exp_drop++;
`endif
    end
    tick();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pop_chk(input int ch, input logic [BW-1:0] act);
    logic [BW-1:0] e;
    int sz;
    sz = (ch == 0) ? q0.size() : (ch == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      chk($sformatf("unexpected_out_ch%0d", ch), 32'(act), 32'hFFFF);
    end else begin
      e = (ch == 0) ? q0.pop_front() : (ch == 1) ? q1.pop_front() : q2.pop_front();
      chk($sformatf("data_ch%0d", ch), 32'(act), 32'(e));
    end
  endtask

  // Monitor: compares every presented word against the per-channel expectation queue
  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (valid_out[i] === 1'b1) pop_chk(i, data_out[i*BW +: BW]);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_L  = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    pause    = '0;
    tick();
    tick();
    chk("reset_valid_out", 32'(valid_out), 32'h0);
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_drop_cnt", 32'(drop_cnt), 32'h0);
    reset_L = 1'b0;

    // Route: two-cycle latency, one word per cycle
    send(6'h05, 1);
    send(6'h15, 1);
    chk("lat_ch0_valid", 32'(valid_out), 32'h1);
    chk("lat_ch0_data", 32'(data_out[5:0]), 32'h05);
    idle(1);
    chk("lat_ch1_valid", 32'(valid_out), 32'h2);
    chk("lat_ch1_data", 32'(data_out[11:6]), 32'h15);
    chk("route_drop", 32'(drop_cnt), 32'(exp_drop));

    // Backpressure and fill
    pause = 3'b001;
    send(6'h01, 1);
    send(6'h02, 1);
    send(6'h03, 1);
    chk("fill3_not_full", 32'(full), 32'h0);
    send(6'h04, 1);
    chk("fill4_full", 32'(full), 32'h1);
    send(6'h0A, 0);
    chk("overflow_full", 32'(full), 32'h1);
    chk("overflow_drop", 32'(drop_cnt), 32'(exp_drop));
    valid_in = 1'b0;
    pause = 3'b000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("drain_valid_%0d", k), 32'(valid_out[0]), 32'h1);
    end
    tick();
    chk("drain_done", 32'(valid_out[0]), 32'h0);
    chk("drain_empty_full", 32'(full), 32'h0);

    // Full with simultaneous pop
    pause = 3'b001;
    send(6'h06, 1);
    send(6'h07, 1);
    send(6'h08, 1);
    send(6'h09, 1);
    chk("sim_prefull", 32'(full), 32'h1);
    pause = 3'b000;
    send(6'h0B, 1);
    chk("sim_still_full", 32'(full), 32'h1);
    chk("sim_pop_valid", 32'(valid_out[0]), 32'h1);
    chk("sim_drop", 32'(drop_cnt), 32'(exp_drop));
    idle(1);
    chk("sim_after_pop", 32'(full), 32'h0);
    idle(6);

    // Invalid destination and channel 2
    send(6'h35, 0);
    send(6'h2C, 1);
    idle(4);
    chk("bad_dest_drop", 32'(drop_cnt), 32'(exp_drop));

    // Reset mid-stream flushes buffered words
    pause = 3'b010;
    send(6'h11, 1);
    send(6'h12, 1);
    send(6'h13, 1);
    idle(1);
    reset_L  = 1'b1;
    valid_in = 1'b1;
    data_in  = 6'h14;
    q1.delete();
    exp_drop = 0;
    tick();
    reset_L  = 1'b0;
    valid_in = 1'b0;
    pause    = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_reset_valid_%0d", k), 32'(valid_out), 32'h0);
    end
    chk("post_reset_full", 32'(full), 32'h0);
    chk("post_reset_drop", 32'(drop_cnt), 32'h0);
    send(6'h1F, 1);
    idle(1);
    chk("post_reset_first", 32'(valid_out), 32'h2);

    // Drop counter saturation
    for (int k = 0; k < 5; k++) send(6'h30 + 6'(k), 0);
    idle(1);
    chk("sat_drop", 32'(drop_cnt), 32'(exp_drop));

    for (int k = 0; k < 40 && (q0.size() + q1.size() + q2.size()) != 0; k++) tick();
    chk("q0_empty", 32'(q0.size()), 32'h0);
    chk("q1_empty", 32'(q1.size()), 32'h0);
    chk("q2_empty", 32'(q2.size()), 32'h0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
